universal_shift_register: RTL

//  Parametrised DEPTH-stage x WIDTH-bit shift register with four modes:

---
 rtl/universal_shift_register_pkg.sv | 14 +
 rtl/usr_stage.sv | 37 +++
 rtl/universal_shift_register.sv | 95 +++++++++
 3 files changed

// File: rtl/universal_shift_register_pkg.sv
// Shared mode encodings and the counter-width helper for the universal shift register.
package universal_shift_register_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   // Drain counter must represent 0..depth inclusive.
   function automatic int usr_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/usr_stage.sv
// One WIDTH-bit stage of the shift register: register plus hold/right/left/load next-value mux.
module usr_stage
   import universal_shift_register_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       i_sel,
   input  logic [WIDTH-1:0] i_from_right,
   input  logic [WIDTH-1:0] i_from_left,
   input  logic [WIDTH-1:0] i_load,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_next;

   always_comb begin
      w_next = r_q;
      unique case (i_sel)
         MODE_HOLD: w_next = r_q;
         MODE_SHR:  w_next = i_from_right;
         MODE_SHL:  w_next = i_from_left;
         MODE_LOAD: w_next = i_load;
         default:   w_next = r_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_q <= '0;
      else        r_q <= w_next;
   end

   assign o_q = r_q;

endmodule

// File: rtl/universal_shift_register.sv
// DEPTH x WIDTH universal shift register (hold/SHR/SHL/load) with drain-complete pulse.
// Define USR_ROTATE_EN to recirculate the outgoing word instead of shifting in sin.
module universal_shift_register
   import universal_shift_register_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [1:0]             mode,
   input  logic [WIDTH-1:0]       sin,
   input  logic [DEPTH*WIDTH-1:0] pin,
   output logic [DEPTH*WIDTH-1:0] pout,
   output logic [WIDTH-1:0]       sout_r,
   output logic [WIDTH-1:0]       sout_l,
   output logic                   done
);

   localparam int                CNT_W    = usr_cnt_w(DEPTH);
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEPTH - 1);

   logic [WIDTH-1:0] w_q [DEPTH];
   logic [1:0]       w_sel;
   logic [WIDTH-1:0] w_shr_in;
   logic [WIDTH-1:0] w_shl_in;
   logic             w_shift;
   logic [CNT_W-1:0] r_cnt;
   logic             r_done;

   assign w_sel = en ? mode : MODE_HOLD;

`ifdef USR_ROTATE_EN
   assign w_shr_in = w_q[0];
   assign w_shl_in = w_q[DEPTH-1];
`else
   assign w_shr_in = sin;
   assign w_shl_in = sin;
`endif

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] w_from_right;
      logic [WIDTH-1:0] w_from_left;

      if (gi == DEPTH - 1) begin : g_top
         assign w_from_right = w_shr_in;
      end else begin : g_mid_r
         assign w_from_right = w_q[gi+1];
      end

      if (gi == 0) begin : g_bot
         assign w_from_left = w_shl_in;
      end else begin : g_mid_l
         assign w_from_left = w_q[gi-1];
      end

      usr_stage #(.WIDTH(WIDTH)) u_stage (
         .clk          (clk),
         .rst_n        (rst_n),
         .i_sel        (w_sel),
         .i_from_right (w_from_right),
         .i_from_left  (w_from_left),
         .i_load       (pin[gi*WIDTH +: WIDTH]),
         .o_q          (w_q[gi])
      );

      assign pout[gi*WIDTH +: WIDTH] = w_q[gi];
   end

   assign sout_r = w_q[0];
   assign sout_l = w_q[DEPTH-1];

   assign w_shift = (w_sel == MODE_SHR) || (w_sel == MODE_SHL);

   // cnt == DEPTH means drained; done marks the shift that reaches it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt  <= CNT_FULL;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_sel == MODE_LOAD) begin
            r_cnt <= '0;
         end else if (w_shift && (r_cnt < CNT_FULL)) begin
            r_cnt  <= r_cnt + 1'b1;
            r_done <= (r_cnt == CNT_LAST);
         end
      end
   end

   assign done = r_done;

endmodule
